// File: rtl/global_control_pipe.sv
// global_control_pipe: multi-lane elastic register pipeline with flush, occupancy and beat counter
module global_control_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int LANES      = 1,
    parameter int DEPTH      = 2,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst,
    input  logic                          flush,
    input  logic [LANES*DATA_WIDTH-1:0]   in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [LANES*DATA_WIDTH-1:0]   out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(DEPTH+1)-1:0]    occupancy,
    output logic [CNT_WIDTH-1:0]          beat_count,
    output logic                          idle
);
    localparam int W  = LANES * DATA_WIDTH;
    localparam int OW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] v, nv, sv;
    logic [DEPTH:0]   r;
    logic [W-1:0]     d [DEPTH];
    logic [W-1:0]     sd [DEPTH];

    // stage i may advance when downstream is ready or any stage at/after i is empty
    assign r[DEPTH] = out_ready;
    for (genvar i = 0; i < DEPTH; i++) begin : g_ready
        assign r[i] = out_ready | ~&v[DEPTH-1:i];
    end

    always_comb begin
        sv[0] = in_valid & ~flush;
        sd[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            sv[i] = v[i-1];
            sd[i] = d[i-1];
        end
        for (int i = 0; i < DEPTH; i++)
            nv[i] = flush ? 1'b0 : (r[i] ? sv[i] : v[i]);
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            v          <= '0;
            occupancy  <= '0;
            beat_count <= '0;
            for (int i = 0; i < DEPTH; i++) d[i] <= '0;
        end else begin
            v         <= nv;
            occupancy <= OW'($countones(nv));
            if (out_valid && out_ready) beat_count <= beat_count + 1'b1;
            for (int i = 0; i < DEPTH; i++)
                if (!flush && r[i] && sv[i]) d[i] <= sd[i];
        end
    end

    assign in_ready  = r[0] & ~flush;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];
    assign idle      = (occupancy == '0);
endmodule

// File: tb/tb_global_control_pipe.sv
// tb_global_control_pipe: randomized check of global_control_pipe against a queue-based reference model
module tb_global_control_pipe;
    localparam int DW = 8, LN = 2, DEPTH = 3, CW = 4;

    logic          ap_clk = 1'b0, ap_rst = 1'b1, flush = 1'b0;
    logic [15:0]   in_data = '0;
    logic          in_valid = 1'b0, out_ready = 1'b0;
    logic          in_ready, out_valid, idle;
    logic [15:0]   out_data;
    logic [1:0]    occupancy;
    logic [CW-1:0] beat_count;

    global_control_pipe #(.DATA_WIDTH(DW), .LANES(LN), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .occupancy(occupancy), .beat_count(beat_count), .idle(idle)
    );

    always #5 ap_clk = ~ap_clk;

    // a beat in flight sits at stage min(age, DEPTH-1-k), k being its queue index
    typedef struct { logic [15:0] data; int age; } beat_t;
    beat_t         q[$];
    logic [15:0]   last_out = '0;
    logic [CW-1:0] cnt = '0;
    int            vectors = 0, miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic iv, input logic [15:0] id, input logic ordy,
                        input logic fl, input logic rs, input bit en);
        logic exp_ov, exp_ir;
        @(negedge ap_clk);
        ap_rst = rs; in_valid = iv; in_data = id; out_ready = ordy; flush = fl;
        #1;
        exp_ov = q.size() > 0 && q[0].age >= DEPTH - 1;
        exp_ir = !fl && (ordy || q.size() < DEPTH);
        if (en) begin
            chk("in_ready", 32'(in_ready), 32'(exp_ir));
            chk("out_valid", 32'(out_valid), 32'(exp_ov));
            chk("out_data", 32'(out_data), 32'(last_out));
            chk("occupancy", 32'(occupancy), q.size());
            chk("idle", 32'(idle), 32'(q.size() == 0));
            chk("beat_count", 32'(beat_count), 32'(cnt));
        end
        if (rs) begin
            q.delete(); last_out = '0; cnt = '0;
        end else begin
            if (exp_ov && ordy) begin
                void'(q.pop_front());
                cnt++;
            end
            if (fl) q.delete();
            else begin
                foreach (q[k]) q[k].age++;
                if (iv && exp_ir) q.push_back('{id, 0});
                if (q.size() > 0 && q[0].age >= DEPTH - 1) last_out = q[0].data;
            end
        end
    endtask

    initial begin
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 1);
        for (int k = 0; k < 24; k++) step(1, {8'(2*k+1), 8'(2*k)}, 1, 0, 0, 1);
        for (int k = 0; k < 6; k++) step(0, 0, 1, 0, 0, 1);
        for (int k = 0; k < 6; k++) step(1, {8'(2*k+1), 8'(2*k)}, 0, 0, 0, 1);
        step(1, 16'h7777, 1, 0, 0, 1);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 6; k++) step(0, 0, 1, 0, 0, 1);
        step(1, 16'hAABB, 0, 0, 0, 1);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 1);
        step(1, 16'hCCDD, 0, 0, 0, 1);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 5; k++) step(0, 0, 1, 0, 0, 1);
        for (int k = 0; k < 3; k++) step(1, 16'($urandom), 0, 0, 0, 1);
        step(1, 16'h1234, 1, 1, 0, 1);
        for (int k = 0; k < 3; k++) step(0, 0, 1, 0, 0, 1);
        for (int k = 0; k < 2; k++) step(1, 16'($urandom), 0, 0, 0, 1);
        step(0, 0, 1, 0, 1, 1);
        for (int k = 0; k < 5; k++) step(0, 0, 1, 0, 0, 1);
        for (int k = 0; k < 2000; k++)
            step($urandom_range(0, 9) < 7, 16'($urandom), $urandom_range(0, 9) < 6,
                 $urandom_range(0, 31) == 0, $urandom_range(0, 99) == 0, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
